// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake and operand/result bundle for the sequential restoring divider.
interface seq_restoring_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one trial subtraction per cycle through a
// subtractor built from 4-bit carry-lookahead blocks (divisor inverted, carry-in 1).
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 8  // must be a multiple of 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_restoring_divider_if.slave  bus
);
  localparam int unsigned NumBlk = WIDTH / 4;
  localparam int unsigned CntW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_r, w_r_d;
  logic [WIDTH-1:0] r_q, w_q_d;
  logic [WIDTH-1:0] r_d, w_d_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic             r_done, w_done_d;
  logic [WIDTH-1:0] r_quot, w_quot_d;
  logic [WIDTH-1:0] r_rem, w_rem_d;
  logic             r_dbz, w_dbz_d;

  // Trial subtraction datapath
  logic [WIDTH:0]   w_s;
  logic [WIDTH-1:0] w_a, w_b, w_g, w_p, w_carry, w_t;
  logic [NumBlk:0]  w_c;
  logic             w_cout, w_accept;

  assign w_s     = {r_r, r_q[WIDTH-1]};
  assign w_a     = w_s[WIDTH-1:0];
  assign w_b     = ~r_d;
  assign w_g     = w_a & w_b;
  assign w_p     = w_a ^ w_b;
  assign w_c[0]  = 1'b1;

  for (genvar blk = 0; blk < NumBlk; blk++) begin : g_cla
    localparam int unsigned B = 4 * blk;
    assign w_carry[B]   = w_c[blk];
    assign w_carry[B+1] = w_g[B] | (w_p[B] & w_c[blk]);
    assign w_carry[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                        | (w_p[B+1] & w_p[B] & w_c[blk]);
    assign w_carry[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                        | (w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c[blk]);
    assign w_c[blk+1]   = w_g[B+3] | (w_p[B+3] & w_g[B+2])
                        | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                        | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_c[blk]);
  end

  assign w_t      = w_p ^ w_carry;
  assign w_cout   = w_c[NumBlk];
  // Shifted-out bit set means the partial remainder already exceeds any divisor.
  assign w_accept = w_s[WIDTH] | w_cout;

  always_comb begin
    w_state_d = r_state;
    w_r_d     = r_r;
    w_q_d     = r_q;
    w_d_d     = r_d;
    w_cnt_d   = r_cnt;
    w_done_d  = 1'b0;
    w_quot_d  = r_quot;
    w_rem_d   = r_rem;
    w_dbz_d   = r_dbz;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_q_d     = bus.dividend;
          w_d_d     = bus.divisor;
          w_r_d     = '0;
          w_cnt_d   = '0;
          w_dbz_d   = 1'b0;
          w_state_d = (bus.divisor == '0) ? StFinish : StRun;
        end
      end
      StRun: begin
        w_r_d   = w_accept ? w_t : w_s[WIDTH-1:0];
        w_q_d   = {r_q[WIDTH-2:0], w_accept};
        w_cnt_d = r_cnt + 1'b1;
        if (r_cnt == CntW'(WIDTH - 1)) w_state_d = StFinish;
      end
      StFinish: begin
        w_done_d = 1'b1;
        // Only the zero-divisor path reaches here with D still zero; Q then holds the dividend.
        if (r_d == '0) begin
          w_quot_d = '1;
          w_rem_d  = r_q;
          w_dbz_d  = 1'b1;
        end else begin
          w_quot_d = r_q;
          w_rem_d  = r_r;
        end
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_r     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_r     <= w_r_d;
      r_q     <= w_q_d;
      r_d     <= w_d_d;
      r_cnt   <= w_cnt_d;
      r_done  <= w_done_d;
      r_quot  <= w_quot_d;
      r_rem   <= w_rem_d;
      r_dbz   <= w_dbz_d;
    end
  end

  assign bus.busy        = (r_state != StIdle);
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed corner cases plus a random sweep
// against a plain-arithmetic reference.
module tb_seq_restoring_divider;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned NumRand = 2000;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  seq_restoring_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issues a division at the current negedge (so back-to-back starts land in the done cycle),
  // waits for done and checks against the reference.
  task automatic do_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit inject, input bit chk_busy);
    int lat;
    int busy_cycles;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_r;
    exp_q = (b == 0) ? {WIDTH{1'b1}} : a / b;
    exp_r = (b == 0) ? a : a % b;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start   = 1'b0;
    lat         = 0;
    busy_cycles = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_cycles++;
      if (inject && lat == 2) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    if (b == 0) check("dbz_latency_le2", 32'(lat <= 2), 32'd1);
    else        check("latency", 32'(lat), 32'(WIDTH + 1));
    if (chk_busy) check("busy_cycles", 32'(busy_cycles), 32'(WIDTH + 1));
    check("quotient", 32'(bus.quotient), 32'(exp_q));
    check("remainder", 32'(bus.remainder), 32'(exp_r));
    check("div_by_zero", 32'(bus.div_by_zero), 32'(b == 0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    bit seen_done;
    n_vec = 0;
    n_err = 0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_quot", 32'(bus.quotient), 32'd0);
    check("rst_rem", 32'(bus.remainder), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_div(8'd100, 8'd7, 1'b0, 1'b1);
    do_div(8'd255, 8'd1, 1'b0, 1'b0);
    do_div(8'd255, 8'd255, 1'b0, 1'b0);
    do_div(8'd5, 8'd9, 1'b0, 1'b0);
    do_div(8'd200, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("done_single_pulse", 32'(bus.done), 32'd0);
    check("dbz_held", 32'(bus.div_by_zero), 32'd1);
    do_div(8'd9, 8'd3, 1'b0, 1'b0);

    // Start during busy is ignored; the follow-up start lands in the done cycle.
    do_div(8'd100, 8'd7, 1'b1, 1'b0);
    do_div(8'd50, 8'd5, 1'b0, 1'b0);

    // Asynchronous reset mid-division.
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_quot", 32'(bus.quotient), 32'd0);
    check("arst_rem", 32'(bus.remainder), 32'd0);
    check("arst_dbz", 32'(bus.div_by_zero), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    check("arst_no_done", 32'(seen_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_div(8'd100, 8'd7, 1'b0, 1'b1);

    for (int n = 0; n < NumRand; n++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
      if (n % 8 == 0) b = WIDTH'($urandom_range(1, 15));
      do_div(a, b, 1'b0, 1'b0);
      q = bus.quotient;
      r = bus.remainder;
      check("invariant_sum", 32'(16'(q) * 16'(b) + 16'(r)), 32'(a));
      check("invariant_rem_lt_div", 32'(r < b), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
